// File: rtl/pixel_stream_feeder.sv
// ---------------------------------------------------------------------------
// pixel_stream_feeder
//   Double-buffered (ping-pong) frame store between an image loader and the
//   first network layer. The loader writes one pixel per cycle in raster
//   order into the current write bank. A full bank is streamed to Layer 1 as
//   numPixels back-to-back pixels. The next frame is only streamed after the
//   network reports completion of the previous frame with nn_done.
//
// Parameters
//   dataWidth  : pixel width in bits
//   numPixels  : pixels per frame (2..1024)
//   addrWidth  : bank address width, 2**addrWidth >= numPixels
//
// Ports
//   clk            in   single clock
//   rst            in   synchronous active-high reset
//   wr_en          in   loader write strobe
//   wr_data        in   pixel value (raster order)
//   wr_ready       out  current write bank can accept a pixel
//   nn_done        in   network finished with the previous frame (pulse)
//   x_valid        out  pixel strobe to Layer 1
//   x_out          out  pixel to Layer 1 (holds when x_valid=0)
//   frame_sent     out  pulse coincident with the last pixel of a frame
//   busy           out  streaming or waiting for nn_done
//   frames_pending out  number of full banks (0..2)
//   overflow       out  sticky, a write was dropped
// ---------------------------------------------------------------------------
module pixel_stream_feeder #(
    parameter int dataWidth = 16,
    parameter int numPixels = 784,
    parameter int addrWidth = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [dataWidth-1:0] wr_data,
    output logic                 wr_ready,
    input  logic                 nn_done,
    output logic                 x_valid,
    output logic [dataWidth-1:0] x_out,
    output logic                 frame_sent,
    output logic                 busy,
    output logic [1:0]           frames_pending,
    output logic                 overflow
);

    localparam int                   DEPTH     = 1 << addrWidth;
    localparam logic [addrWidth-1:0] LAST_ADDR = addrWidth'(numPixels - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT_DONE
    } state_t;

    // Pixel storage: two banks, indexed [bank][address].
    logic [dataWidth-1:0] r_mem [0:1][0:DEPTH-1];

    state_t                r_state;
    logic                  r_wr_bank;
    logic [addrWidth-1:0]  r_wr_ptr;
    logic                  r_rd_bank;
    logic [addrWidth-1:0]  r_rd_addr;
    logic                  r_rd_active;
    logic [1:0]            r_bank_full;
    logic                  r_x_valid;
    logic [dataWidth-1:0]  r_x_out;
    logic                  r_frame_sent;
    logic                  r_busy;
    logic [1:0]            r_frames_pending;
    logic                  r_overflow;

    logic                  w_wr_ready;
    logic                  w_wr_accept;
    logic                  w_wr_last;
    logic                  w_rd_release;
    logic [1:0]            w_bank_full_nxt;

    // Acceptance is decided on the registered flags only, so a write to a
    // bank whose flag is being cleared on this same edge is still dropped.
    always_comb begin
        w_wr_ready      = ~r_bank_full[r_wr_bank];
        w_wr_accept     = wr_en & w_wr_ready;
        w_wr_last       = w_wr_accept && (r_wr_ptr == LAST_ADDR);
        // The registered frame_sent marks the cycle carrying the last pixel.
        w_rd_release    = (r_state == ST_STREAM) && r_frame_sent;
        w_bank_full_nxt = r_bank_full;
        if (w_rd_release) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
        end
        // A completing write always targets an empty bank, so it can never
        // collide with the bank being released above.
        if (w_wr_last) begin
            w_bank_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    // Bank write port: no reset, contents are don't-care until filled.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_bank][r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_wr_bank        <= 1'b0;
            r_wr_ptr         <= '0;
            r_rd_bank        <= 1'b0;
            r_rd_addr        <= '0;
            r_rd_active      <= 1'b0;
            r_bank_full      <= '0;
            r_x_valid        <= 1'b0;
            r_x_out          <= '0;
            r_frame_sent     <= 1'b0;
            r_busy           <= 1'b0;
            r_frames_pending <= '0;
            r_overflow       <= 1'b0;
        end else begin
            r_bank_full      <= w_bank_full_nxt;
            r_frames_pending <= {1'b0, w_bank_full_nxt[0]} + {1'b0, w_bank_full_nxt[1]};

            if (wr_en && !w_wr_ready) begin
                r_overflow <= 1'b1;
            end

            if (w_wr_accept) begin
                if (r_wr_ptr == LAST_ADDR) begin
                    r_wr_ptr  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                end
            end

            r_x_valid    <= 1'b0;
            r_frame_sent <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (r_bank_full[r_rd_bank]) begin
                        r_state     <= ST_STREAM;
                        r_rd_addr   <= '0;
                        r_rd_active <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end

                ST_STREAM: begin
                    // Read is registered: address issued here appears on
                    // x_out one cycle later together with x_valid.
                    if (r_rd_active) begin
                        r_x_valid <= 1'b1;
                        r_x_out   <= r_mem[r_rd_bank][r_rd_addr];
                        if (r_rd_addr == LAST_ADDR) begin
                            r_frame_sent <= 1'b1;
                            r_rd_active  <= 1'b0;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                    end
                    if (r_frame_sent) begin
                        r_state   <= ST_WAIT_DONE;
                        r_rd_bank <= ~r_rd_bank;
                    end
                end

                ST_WAIT_DONE: begin
                    if (nn_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready       = w_wr_ready;
    assign x_valid        = r_x_valid;
    assign x_out          = r_x_out;
    assign frame_sent     = r_frame_sent;
    assign busy           = r_busy;
    assign frames_pending = r_frames_pending;
    assign overflow       = r_overflow;

endmodule
